// File: rtl/button_event_decoder_pkg.sv
// Shared types and defaults for the button event decoder: per-button state
// encoding, timing defaults and counter sizing.
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    localparam int         LONG_CYCLES_DEFAULT   = 25000000;
    localparam int         REPEAT_CYCLES_DEFAULT = 5000000;
    localparam logic [7:0] PARAM_DEFAULT_VALUE   = 8'd128;

    // Bits needed to hold 0..max(a,b)-1; the count stops at its terminal value.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int CNT_W = cnt_width(LONG_CYCLES_DEFAULT, REPEAT_CYCLES_DEFAULT);

endpackage

// File: rtl/btn_event_fsm.sv
// Single-button press/long/repeat/release event generator with registered pulses.
//   state      | meaning
//   ST_IDLE    | button released, waiting for a press
//   ST_PRESSED | pressed, counting toward the long-press threshold
//   ST_HELD    | long press reached, emitting auto-repeat ticks
module btn_event_fsm
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
    parameter int CW            = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse
);

    localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);

    btn_state_t    state;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            count         <= '0;
            press_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (btn) begin
                        state       <= ST_PRESSED;
                        count       <= '0;
                        press_pulse <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // A release wins over a coincident terminal count.
                    if (!btn) begin
                        state         <= ST_IDLE;
                        count         <= '0;
                        release_pulse <= 1'b1;
                    end else if (count == LONG_TC) begin
                        state      <= ST_HELD;
                        count      <= '0;
                        long_pulse <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                ST_HELD: begin
                    if (!btn) begin
                        state         <= ST_IDLE;
                        count         <= '0;
                        release_pulse <= 1'b1;
                    end else if (count == REPEAT_TC) begin
                        count        <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Four-button event decoder driving a saturating 8-bit parameter (up/down/load)
// and a mode flag toggled by button 3.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int         LONG_CYCLES   = LONG_CYCLES_DEFAULT,
    parameter int         REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
    parameter logic [7:0] PARAM_DEFAULT = PARAM_DEFAULT_VALUE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_in,
    output logic [3:0] press_pulse,
    output logic [3:0] long_pulse,
    output logic [3:0] repeat_pulse,
    output logic [3:0] release_pulse,
    output logic [7:0] param_value,
    output logic       param_changed,
    output logic       mode_en
);

    localparam int CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_event_fsm #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CW            (CW)
        ) u_fsm (
            .clk           (clk),
            .rst           (rst),
            .btn           (btn_in[i]),
            .press_pulse   (press_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

    logic       step_up;
    logic       step_down;
    logic [7:0] next_value;

    assign step_up   = press_pulse[0] | repeat_pulse[0];
    assign step_down = press_pulse[1] | repeat_pulse[1];

    // Load overrides stepping; opposing steps cancel; both ends saturate.
    always_comb begin
        next_value = param_value;
        if (press_pulse[2]) begin
            next_value = PARAM_DEFAULT;
        end else if (step_up && !step_down && (param_value != 8'd255)) begin
            next_value = param_value + 8'd1;
        end else if (step_down && !step_up && (param_value != 8'd0)) begin
            next_value = param_value - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            param_value   <= PARAM_DEFAULT;
            param_changed <= 1'b0;
            mode_en       <= 1'b0;
        end else begin
            param_value   <= next_value;
            param_changed <= (next_value != param_value);
            mode_en       <= mode_en ^ press_pulse[3];
        end
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 25000000, hold time in clk cycles before a press becomes a long press.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 5000000, auto-repeat period in clk cycles once long press is reached.
REQ-003 SHALL have parameter PARAM_DEFAULT, default 8'd128, value loaded on reset and on a load event.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port btn_in  input  4  debounced button levels, 1 = pressed; bit0 up, bit1 down, bit2 load default, bit3 mode toggle.
REQ-007 SHALL have port press_pulse  output  4  one-cycle pulse per button on press.
REQ-008 SHALL have port long_pulse  output  4  one-cycle pulse per button when hold reaches LONG_CYCLES.
REQ-009 SHALL have port repeat_pulse  output  4  one-cycle pulse per button every REPEAT_CYCLES after long press.
REQ-010 SHALL have port release_pulse  output  4  one-cycle pulse per button on release.
REQ-011 SHALL have port param_value  output  8  current adjustable parameter.
REQ-012 SHALL have port param_changed  output  1  one-cycle pulse in the cycle param_value takes a new value.
REQ-013 SHALL have port mode_en  output  1  mode flag toggled by button 3.

Function
REQ-014 Each button SHALL run an independent FSM: IDLE, PRESSED, HELD.
REQ-015 IDLE->PRESSED when btn_in[i] is sampled 1; press_pulse[i] SHALL be high in the following cycle (1-cycle latency).
REQ-016 PRESSED SHALL count held cycles from 0; when count reaches LONG_CYCLES-1 with btn_in[i] still 1, SHALL go to HELD, clear count, and pulse long_pulse[i] next cycle.
REQ-017 HELD SHALL pulse repeat_pulse[i] each time count reaches REPEAT_CYCLES-1, then clear count; first repeat occurs REPEAT_CYCLES cycles after long_pulse.
REQ-018 btn_in[i] sampled 0 in PRESSED or HELD SHALL go to IDLE, clear count, and pulse release_pulse[i] next cycle; release has priority over a same-cycle long/repeat terminal count.
REQ-019 Step events: up = press_pulse[0] or repeat_pulse[0]; down = press_pulse[1] or repeat_pulse[1].
REQ-020 param_value SHALL update in the cycle after a step/load event: +1 on up, -1 on down, saturating at 8'd255 and 8'd0.
REQ-021 Simultaneous up and down SHALL leave param_value unchanged.
REQ-022 press_pulse[2] SHALL load PARAM_DEFAULT, overriding any same-cycle up/down.
REQ-023 param_changed SHALL pulse only when param_value actually changes (no pulse when saturated or when load equals current value).
REQ-024 press_pulse[3] SHALL toggle mode_en in the following cycle; long/repeat on button 3 SHALL not toggle.
REQ-025 Counters SHALL be wide enough for max(LONG_CYCLES, REPEAT_CYCLES) and SHALL never wrap.

Reset
REQ-026 On rst high at a clock edge: all FSMs to IDLE, counters 0, all pulse outputs 0, param_changed 0, param_value = PARAM_DEFAULT, mode_en 0.
REQ-027 A button held through reset release SHALL be treated as a new press: press_pulse in the second cycle after rst deasserts.
REQ-028 Reset mid-hold SHALL emit no release_pulse.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, default LONG_CYCLES/REPEAT_CYCLES/PARAM_DEFAULT, and the counter-width constant.
REQ-030 Per-button logic SHALL be one sub-module, btn_event_fsm, instantiated four times; parameter/mode logic stays in the top.

Verification (LONG_CYCLES=10, REPEAT_CYCLES=4)
REQ-031 btn_in=0001 for 3 cycles -> one press_pulse[0], param_value 128->129, one param_changed, release_pulse[0] one cycle after drop.
REQ-032 btn_in[0] held 20 cycles -> press, long_pulse[0] 10 cycles after press, repeat_pulse[0] at +4 and +8 after long; param_value = 131.
REQ-033 param_value 255, press up -> value stays 255, no param_changed; from 0, press down -> stays 0.
REQ-034 btn_in 0011 pressed same cycle -> both press pulses, param_value unchanged; 0101 -> param_value = 128.
REQ-035 btn_in[3] pressed twice -> mode_en 0->1->0; held 20 cycles -> single toggle only.
REQ-036 rst asserted while btn_in[0] held in HELD -> no release_pulse, outputs at reset values; after deassert, press_pulse[0] re-fires.
